// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Brief    : Coin-return engine. Latches a balance on start and pays it out
//            one coin per accepted cycle, largest denomination first, under a
//            ready handshake with the coin chute. Reports any unreturnable
//            remainder with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    // Mirrors the shared vending machine widths (kNumCoins, kTotalBits)
    localparam int c_NUM_COINS  = 3,
    localparam int c_TOTAL_BITS = 31,
    localparam int c_IDX_BITS   = $clog2(c_NUM_COINS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_start,
    input  logic [c_TOTAL_BITS-1:0]       i_amount,
    input  logic [c_NUM_COINS-1:0][31:0]  coin_value,
    input  logic                          i_ready,
    output logic [c_NUM_COINS-1:0]        o_return_coin,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [c_TOTAL_BITS-1:0]       o_remainder,
    output logic [c_TOTAL_BITS-1:0]       o_returned_total
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_DISPENSE = 2'd1;
    localparam logic [1:0] c_ST_DONE     = 2'd2;

    logic [1:0]              r_state;
    logic [c_TOTAL_BITS-1:0] r_remaining;
    logic [c_TOTAL_BITS-1:0] r_returned_total;

    logic                    w_sel_valid;
    logic [c_IDX_BITS-1:0]   w_sel_idx;
    logic [c_TOTAL_BITS-1:0] w_sel_value;
    logic [c_TOTAL_BITS-1:0] w_rem_after;
    logic                    w_rem_after_small;
    logic                    w_amount_small;

    // Pick the largest denomination that still fits in the remaining balance.
    // Ascending scan: the last fitting index wins.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        for (int j = 0; j < c_NUM_COINS; j++) begin
            if ({1'b0, r_remaining} >= coin_value[j]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = j[c_IDX_BITS-1:0];
            end
        end
    end

    // A selected coin never exceeds the balance, so its low bits carry its
    // full value and the subtraction below cannot underflow.
    assign w_sel_value       = coin_value[w_sel_idx][c_TOTAL_BITS-1:0];
    assign w_rem_after       = r_remaining - w_sel_value;
    assign w_rem_after_small = ({1'b0, w_rem_after} < coin_value[0]);
    assign w_amount_small    = ({1'b0, i_amount} < coin_value[0]);

    // Control FSM plus balance/total bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= c_ST_IDLE;
            r_remaining      <= '0;
            r_returned_total <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (i_start) begin
                        r_remaining      <= i_amount;
                        r_returned_total <= '0;
                        r_state          <= w_amount_small ? c_ST_DONE : c_ST_DISPENSE;
                    end
                end
                c_ST_DISPENSE: begin
                    if (i_ready && w_sel_valid) begin
                        r_remaining      <= w_rem_after;
                        r_returned_total <= r_returned_total + w_sel_value;
                        if (w_rem_after_small) begin
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // One-hot coin presentation, independent of the chute's ready.
    always_comb begin
        o_return_coin = '0;
        if (r_state == c_ST_DISPENSE && w_sel_valid) begin
            o_return_coin[w_sel_idx] = 1'b1;
        end
    end

    assign o_busy           = (r_state == c_ST_DISPENSE) || (r_state == c_ST_DONE);
    assign o_done           = (r_state == c_ST_DONE);
    assign o_remainder      = o_done ? r_remaining : '0;
    assign o_returned_total = r_returned_total;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser
// Brief    : Self-checking bench for change_dispenser. Table of payout
//            vectors plus hand-written backpressure, ignored-start and
//            asynchronous-reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

    typedef struct {
        logic [30:0] amount;
        int          n_coins;
        logic [2:0]  coins [4];
        logic [30:0] remainder;
        logic [30:0] total;
    } vec_t;

    logic              r_clk = 1'b0;
    logic              r_reset;
    logic              r_start;
    logic [30:0]       r_amount;
    logic [2:0][31:0]  r_coin_value;
    logic              r_ready;
    logic [2:0]        w_return_coin;
    logic              w_busy;
    logic              w_done;
    logic [30:0]       w_remainder;
    logic [30:0]       w_returned_total;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    change_dispenser u_dut (
        .clk              (r_clk),
        .reset            (r_reset),
        .i_start          (r_start),
        .i_amount         (r_amount),
        .coin_value       (r_coin_value),
        .i_ready          (r_ready),
        .o_return_coin    (w_return_coin),
        .o_busy           (w_busy),
        .o_done           (w_done),
        .o_remainder      (w_remainder),
        .o_returned_total (w_returned_total)
    );

    always #5 r_clk = ~r_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic add_vec(input logic [30:0] amount, input int n,
                           input logic [2:0] c0, input logic [2:0] c1,
                           input logic [2:0] c2, input logic [2:0] c3,
                           input logic [30:0] rem, input logic [30:0] tot);
        vec_t v;
        v.amount    = amount;
        v.n_coins   = n;
        v.coins[0]  = c0;
        v.coins[1]  = c1;
        v.coins[2]  = c2;
        v.coins[3]  = c3;
        v.remainder = rem;
        v.total     = tot;
        vecs.push_back(v);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_coin"},  64'(w_return_coin), 64'd0);
        chk({tag, "_busy"},  64'(w_busy), 64'd0);
        chk({tag, "_done"},  64'(w_done), 64'd0);
        chk({tag, "_rem"},   64'(w_remainder), 64'd0);
    endtask

    task automatic start(input logic [30:0] amount);
        r_start  = 1'b1;
        r_amount = amount;
        tick();
        r_start  = 1'b0;
    endtask

    // Applies one table entry with ready held high and checks every cycle.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d_%0d", idx, v.amount);
        r_ready = 1'b1;
        start(v.amount);
        for (int k = 0; k < v.n_coins; k++) begin
            chk($sformatf("%s_coin%0d", tag, k), 64'(w_return_coin), 64'(v.coins[k]));
            chk($sformatf("%s_busy%0d", tag, k), 64'(w_busy), 64'd1);
            chk($sformatf("%s_nodone%0d", tag, k), 64'(w_done), 64'd0);
            tick();
        end
        chk({tag, "_done"},      64'(w_done), 64'd1);
        chk({tag, "_done_busy"}, 64'(w_busy), 64'd1);
        chk({tag, "_done_coin"}, 64'(w_return_coin), 64'd0);
        chk({tag, "_remainder"}, 64'(w_remainder), 64'(v.remainder));
        chk({tag, "_total"},     64'(w_returned_total), 64'(v.total));
        tick();
        chk_idle_outputs({tag, "_idle"});
        chk({tag, "_total_hold"}, 64'(w_returned_total), 64'(v.total));
    endtask

    initial begin
        r_coin_value = {32'd1000, 32'd500, 32'd100};
        r_reset  = 1'b1;
        r_start  = 1'b0;
        r_amount = '0;
        r_ready  = 1'b1;

        add_vec(31'd1700, 4, 3'b100, 3'b010, 3'b001, 3'b001, 31'd0,  31'd1700);
        add_vec(31'd650,  2, 3'b010, 3'b001, 3'b000, 3'b000, 31'd50, 31'd600);
        add_vec(31'd0,    0, 3'b000, 3'b000, 3'b000, 3'b000, 31'd0,  31'd0);
        add_vec(31'd99,   0, 3'b000, 3'b000, 3'b000, 3'b000, 31'd99, 31'd0);
        add_vec(31'd2600, 4, 3'b100, 3'b100, 3'b010, 3'b001, 31'd0,  31'd2600);
        add_vec(31'd1100, 2, 3'b100, 3'b001, 3'b000, 3'b000, 31'd0,  31'd1100);
        add_vec(31'd1000, 1, 3'b100, 3'b000, 3'b000, 3'b000, 31'd0,  31'd1000);
        add_vec(31'd199,  1, 3'b001, 3'b000, 3'b000, 3'b000, 31'd99, 31'd100);
        add_vec(31'd100,  1, 3'b001, 3'b000, 3'b000, 3'b000, 31'd0,  31'd100);

        tick();
        tick();
        chk_idle_outputs("reset");
        chk("reset_total", 64'(w_returned_total), 64'd0);
        r_reset = 1'b0;
        tick();
        chk_idle_outputs("post_reset");

        foreach (vecs[i]) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: 1500 with ready low for the first three cycles.
        r_ready = 1'b0;
        start(31'd1500);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_hold_coin%0d", k), 64'(w_return_coin), 64'b100);
            chk($sformatf("bp_hold_total%0d", k), 64'(w_returned_total), 64'd0);
            tick();
        end
        r_ready = 1'b1;
        chk("bp_coin_1000", 64'(w_return_coin), 64'b100);
        tick();
        chk("bp_coin_500", 64'(w_return_coin), 64'b010);
        chk("bp_total_mid", 64'(w_returned_total), 64'd1000);
        chk("bp_nodone", 64'(w_done), 64'd0);
        tick();
        chk("bp_done", 64'(w_done), 64'd1);
        chk("bp_rem", 64'(w_remainder), 64'd0);
        chk("bp_total", 64'(w_returned_total), 64'd1500);
        tick();
        chk("bp_idle_busy", 64'(w_busy), 64'd0);

        // Start during DISPENSE must be ignored.
        start(31'd1700);
        chk("ign_coin0", 64'(w_return_coin), 64'b100);
        r_start  = 1'b1;
        r_amount = 31'd9999;
        tick();
        r_start  = 1'b0;
        chk("ign_coin1", 64'(w_return_coin), 64'b010);
        tick();
        chk("ign_coin2", 64'(w_return_coin), 64'b001);
        tick();
        chk("ign_coin3", 64'(w_return_coin), 64'b001);
        tick();
        chk("ign_done", 64'(w_done), 64'd1);
        chk("ign_total", 64'(w_returned_total), 64'd1700);
        chk("ign_rem", 64'(w_remainder), 64'd0);
        tick();
        chk("ign_idle_busy", 64'(w_busy), 64'd0);
        tick();
        chk("ign_not_requeued", 64'(w_busy), 64'd0);

        // Asynchronous reset during the second coin of 1700.
        start(31'd1700);
        chk("ar_coin0", 64'(w_return_coin), 64'b100);
        tick();
        chk("ar_coin1", 64'(w_return_coin), 64'b010);
        #2;
        r_reset = 1'b1;
        #1;
        chk_idle_outputs("ar_immediate");
        chk("ar_total", 64'(w_returned_total), 64'd0);
        tick();
        r_reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("ar_nodone%0d", k), 64'(w_done), 64'd0);
            chk($sformatf("ar_nobusy%0d", k), 64'(w_busy), 64'd0);
            tick();
        end
        start(31'd500);
        chk("ar_after_coin", 64'(w_return_coin), 64'b010);
        tick();
        chk("ar_after_done", 64'(w_done), 64'd1);
        chk("ar_after_total", 64'(w_returned_total), 64'd500);
        chk("ar_after_rem", 64'(w_remainder), 64'd0);
        tick();
        chk("ar_after_idle", 64'(w_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
